// File: rtl/key_pkg.sv
// Shared ASCII key codes, FSM state types and the plain-keymap decoder for uart_key_decoder.
package key_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h61;  // 'a'
  localparam logic [7:0] KEY_RIGHT = 8'h64;  // 'd'
  localparam logic [7:0] KEY_STOP  = 8'h73;  // 's'
  localparam logic [7:0] KEY_FIRE  = 8'h20;  // ' '
  localparam logic [7:0] KEY_START = 8'h0D;  // CR
  localparam logic [7:0] KEY_PAUSE = 8'h70;  // 'p'
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_CSI   = 8'h5B;  // '['
  localparam logic [7:0] KEY_ARR_L = 8'h44;  // 'D'
  localparam logic [7:0] KEY_ARR_R = 8'h43;  // 'C'

  typedef enum logic [1:0] {IDLE, POP, SETTLE} rd_state_t;
  typedef enum logic [1:0] {NONE, ESC_SEEN, CSI_SEEN} esc_state_t;
  typedef enum logic [2:0] {
    ACT_NONE, ACT_LEFT, ACT_RIGHT, ACT_STOP, ACT_FIRE, ACT_START, ACT_PAUSE
  } key_act_t;

  // Letters fold to lower case by forcing bit 5; only 0x41/0x61 etc. alias.
  function automatic key_act_t decode_plain(input logic [7:0] b);
    logic [7:0] lc;
    lc = b | 8'h20;
    if (b == KEY_FIRE)        return ACT_FIRE;
    else if (b == KEY_START)  return ACT_START;
    else if (lc == KEY_LEFT)  return ACT_LEFT;
    else if (lc == KEY_RIGHT) return ACT_RIGHT;
    else if (lc == KEY_STOP)  return ACT_STOP;
    else if (lc == KEY_PAUSE) return ACT_PAUSE;
    else                      return ACT_NONE;
  endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Down-counter that keeps a movement level alive; expire_o flags the 1->0 step
// unless a load or clear lands on the same cycle.
module key_hold_timer #(
  parameter int HOLD_CYCLES = 55_000_000,
  parameter int HOLD_W      = 26
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam logic [HOLD_W-1:0] LOAD_VAL = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] ONE      = HOLD_W'(1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = LOAD_VAL;
    else if (clear_i)       cnt_d = '0;
    else if (cnt_q != '0)   cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == ONE) && !load_i && !clear_i;

endmodule

// File: rtl/uart_key_decoder.sv
// Pops RX FIFO bytes (IDLE->POP->SETTLE) and decodes keystrokes into game controls.
// Optional ANSI arrow decoding is enabled by defining ARROW_KEYS_EN.
module uart_key_decoder
  import key_pkg::*;
#(
  parameter int HOLD_CYCLES = 55_000_000,
  parameter int HOLD_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       move_left,
  output logic       move_right,
  output logic       fire,
  output logic       start,
  output logic       paused,
  output logic [7:0] last_key,
  output logic       key_valid
);

  rd_state_t  state_q;
  logic [7:0] byte_q, last_key_q;
  logic       rd_uart_q, left_q, right_q, fire_q, start_q, paused_q, key_valid_q;
  key_act_t   act;
  logic       hold_load, hold_clear, hold_expire;

`ifdef ARROW_KEYS_EN
  esc_state_t esc_q, esc_d;

  // A byte that breaks a partial sequence falls through to the plain map.
  always_comb begin
    act   = decode_plain(byte_q);
    esc_d = NONE;
    if (esc_q == ESC_SEEN && byte_q == KEY_CSI) begin
      act   = ACT_NONE;
      esc_d = CSI_SEEN;
    end else if (esc_q == CSI_SEEN && byte_q == KEY_ARR_L) begin
      act = ACT_LEFT;
    end else if (esc_q == CSI_SEEN && byte_q == KEY_ARR_R) begin
      act = ACT_RIGHT;
    end else if (byte_q == KEY_ESC) begin
      esc_d = ESC_SEEN;
    end
  end
`else
  always_comb begin
    act = decode_plain(byte_q);
  end
`endif

  assign hold_load  = (state_q == POP) && (act == ACT_LEFT || act == ACT_RIGHT);
  assign hold_clear = (state_q == POP) && (act == ACT_STOP);

  key_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) u_hold (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .expire_o(hold_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      last_key_q  <= '0;
      rd_uart_q   <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      fire_q      <= 1'b0;
      start_q     <= 1'b0;
      paused_q    <= 1'b0;
      key_valid_q <= 1'b0;
`ifdef ARROW_KEYS_EN
      esc_q       <= NONE;
`endif
    end else begin
      rd_uart_q   <= 1'b0;
      fire_q      <= 1'b0;
      start_q     <= 1'b0;
      key_valid_q <= 1'b0;
      if (hold_expire) begin
        left_q  <= 1'b0;
        right_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!rx_empty) begin
            byte_q    <= r_data;
            rd_uart_q <= 1'b1;
            state_q   <= POP;
          end
        end
        POP: begin
          last_key_q  <= byte_q;
          key_valid_q <= 1'b1;
          state_q     <= SETTLE;
`ifdef ARROW_KEYS_EN
          esc_q       <= esc_d;
`endif
          case (act)
            ACT_LEFT:  begin left_q <= 1'b1; right_q <= 1'b0; end
            ACT_RIGHT: begin left_q <= 1'b0; right_q <= 1'b1; end
            ACT_STOP:  begin left_q <= 1'b0; right_q <= 1'b0; end
            ACT_FIRE:  fire_q   <= 1'b1;
            ACT_START: start_q  <= 1'b1;
            ACT_PAUSE: paused_q <= ~paused_q;
            default:   ;
          endcase
        end
        SETTLE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_uart    = rd_uart_q;
  assign move_left  = left_q;
  assign move_right = right_q;
  assign fire       = fire_q;
  assign start      = start_q;
  assign paused     = paused_q;
  assign last_key   = last_key_q;
  assign key_valid  = key_valid_q;

endmodule
